// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and datapath width,
// imported by the ALU and by the decoder/control unit.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_MOV  = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b0111;
    localparam logic [OP_W-1:0] OP_ROL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_ROR  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b1010;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b1011;
    localparam logic [OP_W-1:0] OP_SWAP = 4'b1100;
    localparam logic [OP_W-1:0] OP_INC  = 4'b1101;
    localparam logic [OP_W-1:0] OP_DEC  = 4'b1110;
    localparam logic [OP_W-1:0] OP_RSVD = 4'b1111;

endpackage

// File: rtl/alu.sv
// 8-bit ALU with registered carry/zero flags for conditional sequencing.
// Latency: result is combinational (0 cycles); flags update one edge later when en=1.
// Backpressure: none; flags simply hold while en is low.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W-1:0]   w_result;
    logic                w_cout;
    logic [2*DATA_W-1:0] w_rotl;
    logic [2*DATA_W-1:0] w_rotr;
    logic                r_carry;
    logic                r_zero;

    // Rotates via a doubled operand: the wrapped bits fall out of the shifted copy.
    assign w_rotl = {A, A} << B[2:0];
    assign w_rotr = {A, A} >> B[2:0];

    always_comb begin
        w_result = '0;
        w_cout   = 1'b0;
        case (opcode)
            OP_NOP:  w_result = '0;
            OP_ADD:  {w_cout, w_result} = {1'b0, A} + {1'b0, B};
            OP_SUB: begin
                w_result = A - B;
                w_cout   = (A < B);
            end
            OP_XOR:  w_result = A ^ B;
            OP_MOV:  w_result = B;
            OP_AND:  w_result = A & B;
            OP_OR:   w_result = A | B;
            OP_NOT:  w_result = ~A;
            OP_ROL:  w_result = w_rotl[2*DATA_W-1:DATA_W];
            OP_ROR:  w_result = w_rotr[DATA_W-1:0];
            OP_SHL: begin
                w_result = {A[DATA_W-2:0], 1'b0};
                w_cout   = A[DATA_W-1];
            end
            OP_SHR: begin
                w_result = {1'b0, A[DATA_W-1:1]};
                w_cout   = A[0];
            end
            OP_SWAP: w_result = {A[3:0], A[7:4]};
            OP_INC: begin
                w_result = A + 8'd1;
                w_cout   = (A == 8'hFF);
            end
            OP_DEC: begin
                w_result = A - 8'd1;
                w_cout   = (A == 8'h00);
            end
            OP_RSVD: w_result = '0;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (en) begin
            r_carry <= w_cout;
            r_zero  <= (w_result == '0);
        end
    end

    assign result = w_result;
    assign carry  = r_carry;
    assign zero   = r_zero;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors for every result path and flag rule.
module tb_alu;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] opcode;
    logic [7:0] result;
    logic       carry;
    logic       zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .A      (A),
        .B      (B),
        .opcode (opcode),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; A = 8'h00; B = 8'h00; opcode = OP_NOP;
        #12;
        chk1("rst_carry", carry, 1'b0);
        chk1("rst_zero",  zero,  1'b0);
        @(negedge clk); rst_n = 1'b1;

        // Combinational result, no clock involved
        A = 8'd10; B = 8'd5;
        opcode = OP_ADD; #10; chk8("add_10_5", result, 8'd15);
        opcode = OP_SUB; #10; chk8("sub_10_5", result, 8'd5);
        opcode = OP_XOR; #10; chk8("xor_10_5", result, 8'd15);
        opcode = OP_MOV; #10; chk8("mov_10_5", result, 8'd5);
        opcode = OP_AND; #10; chk8("and_10_5", result, 8'h00);
        opcode = OP_OR;  #10; chk8("or_10_5",  result, 8'h0F);
        opcode = OP_NOT; #10; chk8("not_10",   result, 8'hF5);

        // ADD overflow sets both flags
        @(negedge clk); A = 8'hFF; B = 8'h01; opcode = OP_ADD; en = 1'b1;
        #1; chk8("add_ff_1", result, 8'h00);
        edge_clk();
        chk1("add_ff_carry", carry, 1'b1);
        chk1("add_ff_zero",  zero,  1'b1);

        // SUB borrow, then flags hold with en low
        @(negedge clk); A = 8'd5; B = 8'd10; opcode = OP_SUB;
        #1; chk8("sub_5_10", result, 8'd251);
        edge_clk();
        chk1("sub_borrow", carry, 1'b1);
        chk1("sub_zero",   zero,  1'b0);
        @(negedge clk); en = 1'b0; opcode = OP_XOR;
        #1; chk8("xor_5_10", result, 8'd15);
        chk1("opchg_carry_hold", carry, 1'b1);
        edge_clk();
        chk1("en0_carry_hold", carry, 1'b1);
        chk1("en0_zero_hold",  zero,  1'b0);

        // Rotates and shifts on 8'h81
        @(negedge clk); A = 8'h81; B = 8'h01; en = 1'b1;
        opcode = OP_ROL; #1; chk8("rol_81_1", result, 8'h03);
        opcode = OP_ROR; #1; chk8("ror_81_1", result, 8'hC0);
        B = 8'h00;
        opcode = OP_ROL; #1; chk8("rol_81_0", result, 8'h81);
        opcode = OP_ROR; #1; chk8("ror_81_0", result, 8'h81);
        B = 8'h0B;
        opcode = OP_ROL; #1; chk8("rol_81_3", result, 8'h0C);
        edge_clk();
        chk1("rol_carry", carry, 1'b0);
        @(negedge clk); opcode = OP_SHL;
        #1; chk8("shl_81", result, 8'h02);
        edge_clk();
        chk1("shl_carry", carry, 1'b1);
        @(negedge clk); opcode = OP_SHR;
        #1; chk8("shr_81", result, 8'h40);
        edge_clk();
        chk1("shr_carry", carry, 1'b1);
        @(negedge clk); opcode = OP_SWAP;
        #1; chk8("swap_81", result, 8'h18);
        edge_clk();
        chk1("swap_carry", carry, 1'b0);
        chk1("swap_zero",  zero,  1'b0);

        // INC/DEC wrap, NOP and reserved
        @(negedge clk); A = 8'hFF; opcode = OP_INC;
        #1; chk8("inc_ff", result, 8'h00);
        edge_clk();
        chk1("inc_carry", carry, 1'b1);
        chk1("inc_zero",  zero,  1'b1);
        @(negedge clk); A = 8'h00; opcode = OP_DEC;
        #1; chk8("dec_00", result, 8'hFF);
        edge_clk();
        chk1("dec_carry", carry, 1'b1);
        chk1("dec_zero",  zero,  1'b0);
        @(negedge clk); A = 8'h5A; B = 8'hA5; opcode = OP_NOP;
        #1; chk8("nop", result, 8'h00);
        edge_clk();
        chk1("nop_carry", carry, 1'b0);
        chk1("nop_zero",  zero,  1'b1);
        @(negedge clk); A = 8'hFF; B = 8'hFF; opcode = OP_RSVD;
        #1; chk8("rsvd", result, 8'h00);

        // Async reset between edges
        @(negedge clk); A = 8'hFF; B = 8'h01; opcode = OP_ADD;
        edge_clk();
        chk1("pre_rst_carry", carry, 1'b1);
        chk1("pre_rst_zero",  zero,  1'b1);
        #2; rst_n = 1'b0;
        #1;
        chk1("async_rst_carry", carry, 1'b0);
        chk1("async_rst_zero",  zero,  1'b0);
        A = 8'd3; B = 8'd4;
        #1; chk8("rst_result_tracks", result, 8'd7);
        edge_clk();
        chk1("rst_hold_carry", carry, 1'b0);
        @(negedge clk); rst_n = 1'b1; A = 8'hFF; B = 8'h02;
        #1; chk8("post_rst_add", result, 8'h01);
        edge_clk();
        chk1("post_rst_carry", carry, 1'b1);
        chk1("post_rst_zero",  zero,  1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
